serial_reduce_or_ctrl: RTL and testbench

Sequencer that computes the OR-reduction of a `COUNT_OF_BITS`-wide vector bit-serially through a single shared two-input `pierce_or` cell, instead of the fully unrolled `COUNT_OF_BITS-1` cell chain. It captures an operand on a start handshake, feeds one bit per cycle into the cell with a registered accumulator, and reports the result with a one-cycle `done` pulse. It trades latency for area in the reduction exercises and is the template for later serial reducers (AND, XOR).

---
 rtl/serial_reduce_or_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_reduce_or_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reduce_or_ctrl.sv
// serial_reduce_or_ctrl: bit-serial OR-reduction of a COUNT_OF_BITS-wide operand
// through one shared two-input pierce_or cell and a 1-bit registered accumulator.
// Optional feature macro: REDUCE_SEQ_EARLY_EXIT_EN. When defined, the sequencer
// completes as soon as a set bit is seen. The result is the same; only latency differs.
//
// Handshake: start acts as a request valid and ready as its ready. An operation
// is accepted on a rising edge where start=1 and ready=1. bitvector is captured on
// that edge. start while ready=0 (RUN) is dropped and is not queued. done is a
// one-cycle pulse. reduce is valid from that pulse until the next completion.

// Two-input OR built from its Pierce (NOR) form; the shared reduction cell.
module pierce_or (
  input  logic a,
  input  logic b,
  output logic y
);
  logic nor_ab;

  // NOR followed by inversion gives OR.
  assign nor_ab = ~(a | b);
  assign y      = ~nor_ab;
endmodule

module serial_reduce_or_ctrl #(
  parameter int COUNT_OF_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COUNT_OF_BITS-1:0] bitvector,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic                     reduce,
  output logic [1:0]               state_dbg
);

  localparam int IW = (COUNT_OF_BITS > 1) ? $clog2(COUNT_OF_BITS) : 1;
  localparam int EW = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(COUNT_OF_BITS - 1);
  localparam bit SINGLE = (COUNT_OF_BITS == 1);
`ifdef REDUCE_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic                     acc, acc_n;
  logic [IW-1:0]            idx, idx_n;
  logic [COUNT_OF_BITS-1:0] opnd, opnd_n;
  logic                     reduce_n;
  logic [EW-1:0]            opnd_ext;
  logic                     cell_a;
  logic                     cell_y;

  // The operand is zero-padded to a power of two so every idx value selects a real bit.
  assign opnd_ext = EW'(opnd);
  assign cell_a   = opnd_ext[idx];

  pierce_or u_cell (
    .a (cell_a),
    .b (acc),
    .y (cell_y)
  );

  // Register the state and the datapath. Reset aborts any operation and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= 1'b0;
      idx    <= '0;
      opnd   <= '0;
      reduce <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      idx    <= idx_n;
      opnd   <= opnd_n;
      reduce <= reduce_n;
    end
  end

  // Next state and next datapath values. reduce only updates on entry to DONE.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    idx_n    = idx;
    opnd_n   = opnd;
    reduce_n = reduce;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          opnd_n = bitvector;
          acc_n  = bitvector[0];
          idx_n  = IW'(1);
          if (SINGLE || (EARLY_EXIT && bitvector[0])) begin
            state_n  = S_DONE;
            reduce_n = bitvector[0];
          end else begin
            state_n = S_RUN;
          end
        end else if (state == S_DONE) begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        acc_n = cell_y;
        if ((idx == LAST_IDX) || (EARLY_EXIT && cell_a)) begin
          state_n  = S_DONE;
          reduce_n = cell_y;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state only.
  assign ready     = (state == S_IDLE) || (state == S_DONE);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_reduce_or_ctrl.sv
// Bench for serial_reduce_or_ctrl: an N=4 instance and an N=1 instance share clock and reset.
// Expected results and completion cycles are queued when an operation is issued.
// They are popped and compared when done is observed.
module tb_serial_reduce_or_ctrl;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N=4 instance
  logic         start = 1'b0;
  logic [N-1:0] bitvector = '0;
  logic         ready, busy, done, reduce;
  logic [1:0]   state_dbg;

  // N=1 instance
  logic         start1 = 1'b0;
  logic [0:0]   bitvector1 = '0;
  logic         ready1, busy1, done1, reduce1;
  logic [1:0]   state_dbg1;

  serial_reduce_or_ctrl #(.COUNT_OF_BITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bitvector (bitvector),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .reduce    (reduce),
    .state_dbg (state_dbg)
  );

  serial_reduce_or_ctrl #(.COUNT_OF_BITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .bitvector (bitvector1),
    .ready     (ready1),
    .busy      (busy1),
    .done      (done1),
    .reduce    (reduce1),
    .state_dbg (state_dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int         exp_cyc_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic model_or(input logic [N-1:0] v);
    model_or = 1'b0;
    for (int i = 0; i < N; i++) if (v[i]) model_or = 1'b1;
  endfunction

  function automatic int model_lat(input logic [N-1:0] v);
    model_lat = N;
`ifdef REDUCE_SEQ_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) if (v[i]) model_lat = i + 1;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Presents start for one cycle (cycle k) and records the expected outcome.
  task automatic issue(input logic [N-1:0] v, output int k);
    @(posedge clk); #1;
    start = 1'b1;
    bitvector = v;
    k = cyc;
    exp_q.push_back(model_or(v));
    exp_cyc_q.push_back(k + model_lat(v));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int at, output bit timed_out);
    at = -1;
    timed_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic issue1(input logic v, output int k);
    @(posedge clk); #1;
    start1 = 1'b1;
    bitvector1 = v;
    k = cyc;
    exp_q.push_back(v);
    exp_cyc_q.push_back(k + 1);
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done1(output int at, output bit timed_out);
    at = -1;
    timed_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        at = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ready, busy, done, reduce, state_dbg} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_n4: rdy/busy/done/red/state=%b required 100000",
               {ready, busy, done, reduce, state_dbg});
    end
    vectors++;
    if ({ready1, busy1, done1, reduce1, state_dbg1} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_n1: rdy/busy/done/red/state=%b required 100000",
               {ready1, busy1, done1, reduce1, state_dbg1});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int k, at;
    bit to;
    logic [0:0] er;
    int ec;
    issue(4'b0000, k);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_run_k+%0d: busy=%b done=%b ready=%b required 1 0 0", i, busy, done, ready);
      end
    end
    wait_done(at, to);
    er = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    vectors++;
    if (to || at !== ec) begin
      miscompares++;
      $display("FAIL zero_latency: done cycle=%0d required %0d", at, ec);
    end
    vectors++;
    if (reduce !== er) begin
      miscompares++;
      $display("FAIL zero_result: reduce=%b required %b", reduce, er);
    end
  endtask

  task automatic test_patterns();
    logic [N-1:0] pats[9];
    int k, at, ec;
    bit to;
    logic [0:0] er;
    pats[0] = 4'b0001;
    pats[1] = 4'b1000;
    pats[2] = 4'b0010;
    pats[3] = 4'b0110;
    pats[4] = 4'b1111;
    for (int i = 5; i < 9; i++) pats[i] = N'($urandom_range(0, 15));
    for (int i = 0; i < 9; i++) begin
      issue(pats[i], k);
      wait_done(at, to);
      er = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      vectors++;
      if (to || at !== ec) begin
        miscompares++;
        $display("FAIL pattern_latency %b: done cycle=%0d required %0d", pats[i], at, ec);
      end
      vectors++;
      if (reduce !== er || ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL pattern_result %b: reduce=%b ready=%b busy=%b required %b 1 0",
                 pats[i], reduce, ready, busy, er);
      end
      // done is a single-cycle pulse when no new start follows.
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || reduce !== er) begin
        miscompares++;
        $display("FAIL pattern_pulse %b: done=%b reduce=%b required 0 %b", pats[i], done, reduce, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, at, ec, d;
    bit to;
    logic [0:0] er;
    issue(4'b0100, k);
    // Cycle k+2: a start with a zero operand during RUN must be ignored.
    @(posedge clk); #1;
    start = 1'b1;
    bitvector = 4'b0000;
    wait_done(at, to);
    er = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    vectors++;
    if (to || at !== ec) begin
      miscompares++;
      $display("FAIL b2b_first_latency: done cycle=%0d required %0d", at, ec);
    end
    vectors++;
    if (reduce !== er) begin
      miscompares++;
      $display("FAIL b2b_first_result: reduce=%b required %b", reduce, er);
    end
    // start is still held in the done cycle, so it is accepted there.
    d = at;
    exp_q.push_back(model_or(4'b0000));
    exp_cyc_q.push_back(d + N);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || reduce !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_hold_d+%0d: busy=%b reduce=%b required 1 1", i, busy, reduce);
      end
    end
    wait_done(at, to);
    er = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    vectors++;
    if (to || at !== ec) begin
      miscompares++;
      $display("FAIL b2b_second_latency: done cycle=%0d required %0d", at, ec);
    end
    vectors++;
    if (reduce !== er) begin
      miscompares++;
      $display("FAIL b2b_second_result: reduce=%b required %b", reduce, er);
    end
  endtask

  task automatic test_reset_mid();
    int k, at, ec;
    bit to;
    logic [0:0] er;
    bit seen;
    // Leave reduce at 1 so clearing by reset is visible.
    issue(4'b1000, k);
    wait_done(at, to);
    er = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    vectors++;
    if (to || reduce !== er) begin
      miscompares++;
      $display("FAIL abort_setup: reduce=%b required %b", reduce, er);
    end
    issue(4'b1000, k);
    void'(exp_q.pop_front());
    void'(exp_cyc_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (state_dbg !== 2'd0 || ready !== 1'b1 || reduce !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: state=%0d ready=%b reduce=%b done=%b required 0 1 0 0",
               state_dbg, ready, reduce, done);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_no_done: done pulse seen=1 required 0");
    end
  endtask

  task automatic test_single();
    logic vals[2];
    int k, at, ec;
    bit to;
    logic [0:0] er;
    vals[0] = 1'b1;
    vals[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue1(vals[i], k);
      wait_done1(at, to);
      er = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      vectors++;
      if (to || at !== ec) begin
        miscompares++;
        $display("FAIL single_latency %b: done cycle=%0d required %0d", vals[i], at, ec);
      end
      vectors++;
      if (reduce1 !== er || busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL single_result %b: reduce=%b busy=%b required %b 0", vals[i], reduce1, busy1, er);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    test_single();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
